// File: rtl/kmap_lut_eval_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : kmap_lut_eval_pkg                                                 |
// | Purpose: Shared sizing helpers and table constants for the programmable    |
// |          K-map evaluator (table width, channel-select width, OR default).  |
// | Ports  : none (package)                                                    |
// | Macros : none                                                              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package kmap_lut_eval_pkg;

  // Widest table supported (NUM_IN = 6).
  localparam int KMAP_MAX_TBL_W = 64;

  // Truth-table width for an n-input function.
  function automatic int tbl_w(input int n);
    return 1 << n;
  endfunction

  // Channel-select width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR function table: bit 0 clear, every other bit set. A shift by the full
  // 64 bits yields zero, so the subtraction still wraps to ...FE for n = 6.
  function automatic logic [KMAP_MAX_TBL_W-1:0] kmap_or_default(input int n);
    return (64'd1 << tbl_w(n)) - 64'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kmap_lut_eval_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : kmap_lut_eval_if                                                  |
// | Purpose: Bundles the input stream, output stream and table-write port of   |
// |          the K-map evaluator.                                              |
// | Ports  : in_valid/in_ready/din, out_valid/out_ready/dout,                  |
// |          cfg_valid/cfg_ready/cfg_ch/cfg_table/cfg_commit/cfg_err           |
// |          master = stimulus side, slave = evaluator side                    |
// | Macros : none                                                              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface kmap_lut_eval_if #(
  parameter int NUM_IN = 3,
  parameter int NUM_CH = 4
);
  import kmap_lut_eval_pkg::*;

  localparam int TBL_W = tbl_w(NUM_IN);
  localparam int CH_W  = ch_w(NUM_CH);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*NUM_IN-1:0] din;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH-1:0]        dout;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [CH_W-1:0]          cfg_ch;
  logic [TBL_W-1:0]         cfg_table;
  logic                     cfg_commit;
  logic                     cfg_err;

  modport master (
    output in_valid, din, out_ready, cfg_valid, cfg_ch, cfg_table, cfg_commit,
    input  in_ready, out_valid, dout, cfg_ready, cfg_err
  );

  modport slave (
    input  in_valid, din, out_ready, cfg_valid, cfg_ch, cfg_table, cfg_commit,
    output in_ready, out_valid, dout, cfg_ready, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/kmap_lut_eval_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : kmap_lut_ch                                                       |
// | Purpose: One channel of the K-map evaluator: active truth table, optional  |
// |          shadow table, write/commit handling and combinational lookup.     |
// | Ports  : clk, areset       clock / async active-high reset                 |
// |          wr_en_i           accepted write addressed to this channel        |
// |          wr_table_i        new table contents                              |
// |          commit_i          copy shadow to active (shadow build only)       |
// |          sel_i             input vector, MSB = first variable              |
// |          bit_o             table[sel_i] from the active table              |
// | Macros : KMAP_SHADOW_EN    writes staged in a shadow table until commit    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module kmap_lut_ch
  import kmap_lut_eval_pkg::*;
#(
  parameter  int NUM_IN = 3,
  localparam int TBL_W  = tbl_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              wr_en_i,
  input  logic [TBL_W-1:0]  wr_table_i,
  input  logic              commit_i,
  input  logic [NUM_IN-1:0] sel_i,
  output logic              bit_o
);

  localparam logic [TBL_W-1:0] OR_TBL = TBL_W'(kmap_or_default(NUM_IN));

  logic [TBL_W-1:0] active_q;
  logic [TBL_W-1:0] active_d;

`ifdef KMAP_SHADOW_EN
  logic [TBL_W-1:0] shadow_q;
  logic [TBL_W-1:0] shadow_d;

  // Commit copies the post-write shadow, so a write on the commit edge is
  // already part of the table that becomes active.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en_i)  shadow_d = wr_table_i;
    if (commit_i) active_d = shadow_d;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) shadow_q <= OR_TBL;
    else        shadow_q <= shadow_d;
  end
`else
  always_comb begin
    active_d = active_q;
    if (wr_en_i) active_d = wr_table_i;
  end

  // Commit has no meaning without a shadow table.
  logic unused_commit;
  assign unused_commit = commit_i;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) active_q <= OR_TBL;
    else        active_q <= active_d;
  end

  assign bit_o = active_q[sel_i];

endmodule
`default_nettype wire

// File: rtl/kmap_lut_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : kmap_lut_eval                                                     |
// | Purpose: NUM_CH independent programmable NUM_IN-input truth-table          |
// |          evaluators behind a 2-stage valid/ready pipeline with full        |
// |          backpressure. Reset loads every table with the OR function.       |
// | Ports  : clk               clock, rising edge                              |
// |          areset            asynchronous active-high reset                  |
// |          bus (slave)       in_valid/in_ready/din, out_valid/out_ready/dout,|
// |                            cfg_valid/cfg_ready/cfg_ch/cfg_table/           |
// |                            cfg_commit/cfg_err                              |
// | Macros : KMAP_SHADOW_EN    writes staged until cfg_commit                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module kmap_lut_eval
  import kmap_lut_eval_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int NUM_CH = 4
) (
  input  logic             clk,
  input  logic             areset,
  kmap_lut_eval_if.slave   bus
);

  localparam int DW = NUM_CH * NUM_IN;

  // ready_q keeps both ready outputs low until the first edge after reset.
  logic              ready_q;
  logic              s0_valid_q, s0_valid_d;
  logic [DW-1:0]     s0_data_q,  s0_data_d;
  logic              out_valid_q, out_valid_d;
  logic [NUM_CH-1:0] dout_q,      dout_d;
  logic              cfg_err_q,   cfg_err_d;

  logic              s1_load;
  logic              s0_load;
  logic              in_fire;
  logic              cfg_fire;
  logic              cfg_bad;
  logic              commit;
  logic [NUM_CH-1:0] lut_bit;

  always_comb begin
    s1_load  = !out_valid_q | bus.out_ready;
    s0_load  = !s0_valid_q | s1_load;
    in_fire  = bus.in_valid & ready_q & s0_load;
    cfg_fire = bus.cfg_valid & ready_q;
    cfg_bad  = cfg_fire & (32'(bus.cfg_ch) >= 32'(NUM_CH));
    commit   = bus.cfg_commit & ready_q;
  end

  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_data_d   = s0_data_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    cfg_err_d   = cfg_err_q | cfg_bad;
    if (s0_load) begin
      s0_valid_d = in_fire;
      if (in_fire) s0_data_d = bus.din;
    end
    // dout only moves on a real result so it stays stable while idle.
    if (s1_load) begin
      out_valid_d = s0_valid_q;
      if (s0_valid_q) dout_d = lut_bit;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ready_q     <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_data_q   <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      s0_valid_q  <= s0_valid_d;
      s0_data_q   <= s0_data_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Out-of-range channel numbers match no instance, so such writes drop.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_en;
    assign wr_en = cfg_fire & (32'(bus.cfg_ch) == 32'(g));

    kmap_lut_ch #(
      .NUM_IN (NUM_IN)
    ) u_ch (
      .clk        (clk),
      .areset     (areset),
      .wr_en_i    (wr_en),
      .wr_table_i (bus.cfg_table),
      .commit_i   (commit),
      .sel_i      (s0_data_q[g*NUM_IN +: NUM_IN]),
      .bit_o      (lut_bit[g])
    );
  end

  assign bus.in_ready  = ready_q & s0_load;
  assign bus.cfg_ready = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_kmap_lut_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_kmap_lut_eval                                                  |
// | Purpose: Directed self-checking bench for kmap_lut_eval (NUM_IN=3).        |
// |          Three channels are used so that cfg_ch = NUM_CH is representable  |
// |          in the 2-bit channel field and the error path can be exercised.   |
// | Macros : KMAP_SHADOW_EN    expectations follow the shadow/commit build     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_kmap_lut_eval;

  localparam int NI = 3;
  localparam int NC = 3;
`ifdef KMAP_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset;
  int   n_cmp = 0;
  int   n_fail = 0;

  kmap_lut_eval_if #(.NUM_IN(NI), .NUM_CH(NC)) bus ();

  kmap_lut_eval #(.NUM_IN(NI), .NUM_CH(NC)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] rep(input logic [2:0] v);
    return {v, v, v};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stimulus driver: present one vector, wait for acceptance, then wait for
  // the result and consume it. Checks are done by the callers.
  task automatic run_vec(input logic [8:0] v, output logic [2:0] res,
                         output int lat, output bit ok);
    ok = 1'b0; lat = 0; res = '0;
    bus.in_valid = 1'b1; bus.din = v; bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      cyc();
    end
    bus.in_valid = 1'b0;
    if (!ok) return;
    ok = 1'b0; lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin ok = 1'b1; res = bus.dout; break; end
      cyc();
      lat++;
    end
    if (ok) cyc();
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] tbl, input bit commit);
    bus.cfg_valid = 1'b1; bus.cfg_ch = ch; bus.cfg_table = tbl; bus.cfg_commit = commit;
    cyc();
    bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    bus.in_valid = 1'b0; bus.din = '0; bus.out_ready = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_table = '0; bus.cfg_commit = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 0", bus.cfg_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.dout !== 3'b000) begin n_fail++; $display("FAIL reset_dout: got %b want 000", bus.dout); end
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", bus.cfg_err); end
    areset = 1'b0;
    cyc();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cfg_ready: got %b want 1", bus.cfg_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid); end
  endtask

  // Back-to-back stream 0..7 on every channel through the OR tables.
  task automatic test_back_to_back();
    logic [2:0] exp;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c >= 2 && c <= 9) begin
        exp = (c - 2 != 0) ? 3'b111 : 3'b000;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.dout !== exp) begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%b want v=1 d=%b", c - 2, bus.out_valid, bus.dout, exp); end
      end else begin
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle[c%0d]: got out_valid=%b want 0", c, bus.out_valid); end
      end
      if (c < 8) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[c%0d]: got %b want 1", c, bus.in_ready); end
      end
      bus.in_valid = (c < 8);
      bus.din = rep(3'(c));
      cyc();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_table_write();
    logic [2:0] res; int lat; bit ok;
    cfg_write(2'd1, 8'h96, SHADOW);
    run_vec({3'b000, 3'b011, 3'b011}, res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b001) begin n_fail++; $display("FAIL xor3_in011: got ok=%b d=%b want ok=1 d=001", ok, res); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL latency: got %0d want 2", lat); end
    run_vec({3'b100, 3'b111, 3'b000}, res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b110) begin n_fail++; $display("FAIL xor3_in111: got ok=%b d=%b want ok=1 d=110", ok, res); end
  endtask

  task automatic test_stall();
    logic [8:0] vecs [3];
    logic [2:0] got [$];
    int acc; int idx; bit fire;
    vecs[0] = rep(3'd0); vecs[1] = rep(3'd5); vecs[2] = rep(3'd7);
    acc = 0; idx = 0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.din = vecs[0];
    for (int c = 0; c < 5; c++) begin
      fire = bus.in_ready;
      cyc();
      if (fire) begin acc++; idx++; bus.din = vecs[idx]; end
      if (c >= 1) begin
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.dout !== 3'b000) begin n_fail++; $display("FAIL stall_hold[c%0d]: got v=%b d=%b want v=1 d=000", c, bus.out_valid, bus.dout); end
      end
    end
    n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d want 2", acc); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) got.push_back(bus.dout);
      cyc();
    end
    n_cmp++; if (got.size() !== 2) begin n_fail++; $display("FAIL stall_drain_count: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if (got[0] !== 3'b000 || got[1] !== 3'b101) begin n_fail++; $display("FAIL stall_drain_order: got %b,%b want 000,101", got[0], got[1]); end
    end
  endtask

  // Write ch0 on the same edge S1 loads a ch0 result.
  task automatic test_write_timing();
    bus.out_ready = 1'b1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL wt_in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.din = rep(3'd5);
    cyc();
    bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_table = 8'h00; bus.cfg_commit = SHADOW;
    cyc();
    bus.in_valid = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.dout !== 3'b101) begin n_fail++; $display("FAIL wt_old_table: got v=%b d=%b want v=1 d=101", bus.out_valid, bus.dout); end
    cyc();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.dout !== 3'b100) begin n_fail++; $display("FAIL wt_new_table: got v=%b d=%b want v=1 d=100", bus.out_valid, bus.dout); end
    cyc();
  endtask

  task automatic test_cfg_err();
    logic [2:0] res; int lat; bit ok;
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", bus.cfg_err); end
    cfg_write(2'd3, 8'h00, SHADOW);
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", bus.cfg_err); end
    run_vec(rep(3'd7), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b110) begin n_fail++; $display("FAIL err_tables_kept: got ok=%b d=%b want ok=1 d=110", ok, res); end
    repeat (3) cyc();
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus.cfg_err); end
    #2 areset = 1'b1;
    #1;
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_async_clear: got %b want 0", bus.cfg_err); end
    cyc();
    areset = 1'b0;
    cyc();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rerelease_ready: got in=%b cfg=%b want 1,1", bus.in_ready, bus.cfg_ready); end
    run_vec(rep(3'd1), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b111) begin n_fail++; $display("FAIL reset_restores_or_1: got ok=%b d=%b want ok=1 d=111", ok, res); end
    run_vec(rep(3'd0), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b000) begin n_fail++; $display("FAIL reset_restores_or_0: got ok=%b d=%b want ok=1 d=000", ok, res); end
  endtask

  task automatic test_commit_and_async_reset();
    logic [2:0] res; int lat; bit ok;
    logic [2:0] exp_pre;
    exp_pre = SHADOW ? 3'b000 : 3'b100;
    cfg_write(2'd2, 8'h01, 1'b0);
    run_vec(rep(3'd0), res, lat, ok);
    n_cmp++; if (!ok || res !== exp_pre) begin n_fail++; $display("FAIL commit_pre: got ok=%b d=%b want ok=1 d=%b", ok, res, exp_pre); end
    bus.cfg_commit = 1'b1;
    cyc();
    bus.cfg_commit = 1'b0;
    run_vec(rep(3'd0), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b100) begin n_fail++; $display("FAIL commit_post: got ok=%b d=%b want ok=1 d=100", ok, res); end
    bus.cfg_commit = 1'b1;
    cyc();
    bus.cfg_commit = 1'b0;
    run_vec(rep(3'd0), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b100) begin n_fail++; $display("FAIL commit_idle: got ok=%b d=%b want ok=1 d=100", ok, res); end
    // Fill the pipeline under backpressure, then reset between edges.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.din = rep(3'd3);
    repeat (3) cyc();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_full: got out_valid=%b want 1", bus.out_valid); end
    #2 areset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got v=%b in_ready=%b want 0,0", bus.out_valid, bus.in_ready); end
    cyc();
    areset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_drop: got v=%b in_ready=%b want 0,1", bus.out_valid, bus.in_ready); end
    run_vec(rep(3'd0), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b000) begin n_fail++; $display("FAIL midreset_or_0: got ok=%b d=%b want ok=1 d=000", ok, res); end
    run_vec(rep(3'd4), res, lat, ok);
    n_cmp++; if (!ok || res !== 3'b111) begin n_fail++; $display("FAIL midreset_or_4: got ok=%b d=%b want ok=1 d=111", ok, res); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_table_write();
    test_stall();
    test_write_timing();
    test_cfg_err();
    test_commit_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
